// File: rtl/ex_lsu.sv
// rtl/ex_lsu.sv - EX-stage load/store unit driving the data SRAM request
module ex_lsu #(
    parameter int STALL_WD = 6,
    parameter int AW       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic                id_mem_op,
    input  logic [4:0]          id_load,
    input  logic [2:0]          id_store,
    input  logic [AW-1:0]       id_base,
    input  logic [15:0]         id_offset,
    input  logic [AW-1:0]       id_store_data,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_wen,
    output logic [AW-1:0]       data_sram_addr,
    output logic [AW-1:0]       data_sram_wdata,
    output logic [3:0]          data_ram_sel,
    output logic [4:0]          load_sram_ex_data,
    output logic [2:0]          store_sram_ex_data,
    output logic                ex_misalign,
    output logic [AW-1:0]       ex_bad_addr,
    output logic                stallreq_for_load
);

    logic          op_valid_r;
    logic [4:0]    load_r;
    logic [2:0]    store_r;
    logic [AW-1:0] base_r;
    logic [15:0]   offset_r;
    logic [AW-1:0] sdata_r;
    logic          issued;

    logic          capture;
    logic          bubble;
    logic [AW-1:0] ea;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic [3:0]    lane_sel;

    // EX advances when it is not stopped; it bubbles when stopped but MEM moves on
    assign capture = ~stall[2];
    assign bubble  = stall[2] & ~stall[3];

    // Input register: capture from ID, insert a bubble, or hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid_r <= 1'b0;
            load_r     <= '0;
            store_r    <= '0;
            base_r     <= '0;
            offset_r   <= '0;
            sdata_r    <= '0;
        end else if (bubble) begin
            op_valid_r <= 1'b0;
            load_r     <= '0;
            store_r    <= '0;
            base_r     <= '0;
            offset_r   <= '0;
            sdata_r    <= '0;
        end else if (capture) begin
            op_valid_r <= id_mem_op;
            load_r     <= id_load;
            store_r    <= id_store;
            base_r     <= id_base;
            offset_r   <= id_offset;
            sdata_r    <= id_store_data;
        end
    end

    // Remember that the held op already reached the SRAM so it is not repeated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued <= 1'b0;
        end else if (capture || bubble) begin
            issued <= 1'b0;
        end else if (data_sram_en && stall[3]) begin
            issued <= 1'b1;
        end
    end

    assign ea = base_r + {{(AW-16){offset_r[15]}}, offset_r};

    // load one-hot {lb,lbu,lh,lhu,lw}, store one-hot {sb,sh,sw}
    assign is_byte = load_r[4] | load_r[3] | store_r[2];
    assign is_half = load_r[2] | load_r[1] | store_r[1];
    assign is_word = load_r[0] | store_r[0];

    assign misalign = (is_half & ea[0]) | (is_word & (ea[1:0] != 2'b00));

    // Little-endian byte lanes touched by the access
    always_comb begin
        lane_sel = 4'b0000;
        if (is_byte) begin
            lane_sel = 4'b0001 << ea[1:0];
        end else if (is_half) begin
            lane_sel = ea[1] ? 4'b1100 : 4'b0011;
        end else if (is_word) begin
            lane_sel = 4'b1111;
        end
    end

    // Store data replicated across lanes so the SRAM byte enables pick the right copy
    always_comb begin
        data_sram_wdata = '0;
        if (op_valid_r) begin
            if (store_r[2]) begin
                data_sram_wdata = {4{sdata_r[7:0]}};
            end else if (store_r[1]) begin
                data_sram_wdata = {2{sdata_r[15:0]}};
            end else if (store_r[0]) begin
                data_sram_wdata = sdata_r;
            end
        end
    end

    assign data_sram_en       = op_valid_r & ~misalign & ~issued;
    assign data_sram_wen      = (data_sram_en && (|store_r)) ? lane_sel : 4'b0000;
    assign data_ram_sel       = data_sram_en ? lane_sel : 4'b0000;
    assign data_sram_addr     = op_valid_r ? ea : '0;
    assign load_sram_ex_data  = misalign ? 5'b00000 : load_r;
    assign store_sram_ex_data = misalign ? 3'b000 : store_r;
    assign ex_misalign        = op_valid_r & misalign;
    assign ex_bad_addr        = ex_misalign ? ea : '0;
    assign stallreq_for_load  = op_valid_r & (|load_r) & ~misalign;

endmodule
